// File: rtl/data_ram_dp.sv
// Dual-port synchronous data RAM: port A read/write, port B read-only, with a
// clear engine that sweeps the whole array with CLEAR_VAL after reset or on request.
module data_ram_dp #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 12,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] ram [DEPTH];
  logic              clr_we;
  logic              a_acc;
  logic              b_acc;
  logic              a_wr;
  logic              b_bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ports are locked out for the whole sweep; busy comes straight from the state register.
  always_comb begin
    busy     = (state == CLEAR);
    clr_we   = (state == CLEAR);
    a_acc    = a_en & ~busy;
    b_acc    = b_en & ~busy;
    a_wr     = a_acc & a_we;
    b_bypass = a_wr & (a_addr == b_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else if (clr_req) begin
      clr_cnt <= '0;
    end
  end

  // Array has no reset so it maps onto block RAM; contents survive reset unless cleared.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_cnt] <= CLEAR_VAL;
    end else if (a_wr) begin
      ram[a_addr] <= a_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_acc;
      b_rvalid <= b_acc;
      if (a_acc) begin
        a_rdata <= a_we ? a_wdata : ram[a_addr];
      end
      // Same-cycle A write to the address B is reading is forwarded to B.
      if (b_acc) begin
        b_rdata <= b_bypass ? a_wdata : ram[b_addr];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_dp.sv
// Self-checking bench for data_ram_dp: table-driven port traffic scored against
// per-port expectation queues, plus hand-written clear/reset sequences.
module tb_data_ram_dp;

  typedef struct {
    logic        a_en;
    logic        a_we;
    logic [11:0] a_addr;
    logic [7:0]  a_wdata;
    logic        b_en;
    logic [11:0] b_addr;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clr_req, busy;
  logic        a_en, a_we, a_rvalid, b_en, b_rvalid;
  logic [11:0] a_addr, b_addr;
  logic [7:0]  a_wdata, a_rdata, b_rdata;

  logic        rst0, clr_req0, busy0;
  logic        a_en0, a_we0, a_rvalid0, b_en0, b_rvalid0;
  logic [11:0] a_addr0, b_addr0;
  logic [7:0]  a_wdata0, a_rdata0, b_rdata0;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  exp_t qa[$];
  exp_t qb[$];
  vec_t vecs[13];
  vec_t post[3];

  always #5 clk = ~clk;

  data_ram_dp dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
  );

  data_ram_dp #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .clr_req(clr_req0), .busy(busy0),
    .a_en(a_en0), .a_we(a_we0), .a_addr(a_addr0), .a_wdata(a_wdata0),
    .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_en(b_en0), .b_addr(b_addr0), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one request cycle (called at a falling edge) and records its expected responses.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    a_en    = v.a_en;
    a_we    = v.a_we;
    a_addr  = v.a_addr;
    a_wdata = v.a_wdata;
    b_en    = v.b_en;
    b_addr  = v.b_addr;
    if (v.a_en) begin
      e = '{cyc + 1, v.exp_a};
      qa.push_back(e);
    end
    if (v.b_en) begin
      e = '{cyc + 1, v.exp_b};
      qb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idlePorts();
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_addr = '0;
  endtask

  // Counts falling edges until busy drops; injects ignored traffic and an ignored clr_req.
  task automatic measureSweep(input int wr_at, output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
      if (n == wr_at) begin
        a_en = 1'b1; a_we = 1'b1; a_addr = 12'h005; a_wdata = 8'h55;
        b_en = 1'b1; b_addr = 12'h005;
      end
      if (n == wr_at + 3) idlePorts();
      if (n == wr_at + 50) clr_req = 1'b1;
      if (n == wr_at + 51) clr_req = 1'b0;
    end
    idlePorts();
    clr_req = 1'b0;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      checkOutput("a_rvalid", a_rvalid, 1);
      checkOutput("a_rdata", a_rdata, e.data);
    end else if (a_rvalid) begin
      checkOutput("a_rvalid_unexpected", a_rvalid, 0);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      checkOutput("b_rvalid", b_rvalid, 1);
      checkOutput("b_rdata", b_rdata, e.data);
    end else if (b_rvalid) begin
      checkOutput("b_rvalid_unexpected", b_rvalid, 0);
    end
  end

  initial begin
    int n;
    //            a_en  a_we  a_addr   a_wdata b_en  b_addr   exp_a  exp_b
    vecs[0]  = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 12'h800, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 12'hFFF, 8'h00, 1'b1, 12'h000, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 12'h010, 8'hD3, 1'b0, 12'h000, 8'hD3, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 12'h010, 8'hD3, 8'hD3};
    vecs[4]  = '{1'b1, 1'b1, 12'h0FF, 8'hAA, 1'b1, 12'h0FF, 8'hAA, 8'hAA};
    vecs[5]  = '{1'b1, 1'b0, 12'h005, 8'h00, 1'b1, 12'h0FF, 8'h00, 8'hAA};
    vecs[6]  = '{1'b1, 1'b1, 12'hFFF, 8'h5C, 1'b1, 12'h000, 8'h5C, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 12'hFFF, 8'h00, 1'b1, 12'hFFF, 8'h5C, 8'h5C};
    vecs[8]  = '{1'b0, 1'b1, 12'h123, 8'h99, 1'b0, 12'h000, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 12'h010, 8'h00, 8'hD3};
    vecs[10] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 12'h200, 8'h01, 1'b1, 12'h201, 8'h01, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 12'h200, 8'h00, 1'b1, 12'h0FF, 8'h01, 8'hAA};
    post[0]  = '{1'b1, 1'b0, 12'h020, 8'h00, 1'b1, 12'h010, 8'h00, 8'h00};
    post[1]  = '{1'b1, 1'b0, 12'h005, 8'h00, 1'b1, 12'h0FF, 8'h00, 8'h00};
    post[2]  = '{1'b1, 1'b0, 12'hFFF, 8'h00, 1'b1, 12'h020, 8'h00, 8'h00};

    rst = 1'b1; clr_req = 1'b0; idlePorts();
    rst0 = 1'b1; clr_req0 = 1'b0;
    a_en0 = 1'b0; a_we0 = 1'b0; a_addr0 = '0; a_wdata0 = '0; b_en0 = 1'b0; b_addr0 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 1);
    checkOutput("reset_a_rdata", a_rdata, 0);
    checkOutput("reset_b_rdata", b_rdata, 0);
    checkOutput("reset_a_rvalid", a_rvalid, 0);
    checkOutput("reset_b_rvalid", b_rvalid, 0);
    checkOutput("reset_busy_noclear", busy0, 0);
    rst = 1'b0; rst0 = 1'b0;

    $display("[TB] power-on sweep");
    measureSweep(100, n);
    checkOutput("sweep_len_poweron", n, 4096);
    checkOutput("rdata_hold_busy", a_rdata, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);
    idlePorts();
    repeat (2) @(negedge clk);
    checkOutput("a_rdata_hold_idle", a_rdata, 8'h01);
    checkOutput("b_rdata_hold_idle", b_rdata, 8'hAA);

    $display("[TB] clear request with concurrent write, reset mid-sweep");
    checkOutput("busy_before_req", busy, 0);
    clr_req = 1'b1;
    applyStimulus('{1'b1, 1'b1, 12'h020, 8'h11, 1'b0, 12'h000, 8'h11, 8'h00});
    clr_req = 1'b0;
    idlePorts();
    checkOutput("busy_after_req", busy, 1);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("busy_in_reset", busy, 1);
    checkOutput("a_rdata_in_reset", a_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    measureSweep(100, n);
    checkOutput("sweep_len_restart", n, 4096);
    for (int i = 0; i < 3; i++) applyStimulus(post[i]);
    idlePorts();

    $display("[TB] no-clear-on-reset instance");
    @(negedge clk);
    a_en0 = 1'b1; a_we0 = 1'b1; a_addr0 = 12'h001; a_wdata0 = 8'h7E;
    @(posedge clk); #1;
    checkOutput("nc_write_rvalid", a_rvalid0, 1);
    checkOutput("nc_write_rdata", a_rdata0, 8'h7E);
    @(negedge clk);
    a_en0 = 1'b0; a_we0 = 1'b0;
    rst0 = 1'b1;
    #1;
    checkOutput("nc_reset_busy", busy0, 0);
    checkOutput("nc_reset_a_rdata", a_rdata0, 0);
    checkOutput("nc_reset_a_rvalid", a_rvalid0, 0);
    checkOutput("nc_reset_b_rdata", b_rdata0, 0);
    @(negedge clk);
    rst0 = 1'b0;
    checkOutput("nc_busy_after_reset", busy0, 0);
    a_en0 = 1'b1; a_addr0 = 12'h001; b_en0 = 1'b1; b_addr0 = 12'h001;
    @(posedge clk); #1;
    checkOutput("nc_a_rvalid", a_rvalid0, 1);
    checkOutput("nc_a_rdata", a_rdata0, 8'h7E);
    checkOutput("nc_b_rvalid", b_rvalid0, 1);
    checkOutput("nc_b_rdata", b_rdata0, 8'h7E);
    @(negedge clk);
    a_en0 = 1'b0; b_en0 = 1'b0;
    @(posedge clk); #1;
    checkOutput("nc_a_rvalid_pulse", a_rvalid0, 0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", qa.size() + qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
